// File: rtl/muldiv_controller.sv
// muldiv_controller: iterative RV32M multiply/divide sequencer beside the Execute ALU.
// Shift-add multiply and restoring divide, one bit per cycle, stalling the front end.
module muldiv_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            DoneE,
  output logic [XLEN-1:0] MulDivResultE,
  output logic            BusyE
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [2:0] op;
  logic neg_q, neg_r;
  logic [2*XLEN-1:0] acc, b;
  logic [XLEN-1:0] a, res;
  logic sa_in, sb_in, div0, ovf, special, accept, ge;
  logic [XLEN-1:0] mag_a, mag_b, spec_res, rem_nx, quo_nx, mul_res, div_res, res_calc;
  logic [XLEN:0] rem_sh, diff;
  logic [2*XLEN-1:0] acc_add, prod_s, acc_n, b_n;
  logic [XLEN-1:0] a_n;
  always_comb begin
    sa_in    = (MulDivOpE == 3'b001 || MulDivOpE == 3'b010 || MulDivOpE == 3'b100 || MulDivOpE == 3'b110) && SrcAE[XLEN-1];
    sb_in    = (MulDivOpE == 3'b001 || MulDivOpE == 3'b100 || MulDivOpE == 3'b110) && SrcBE[XLEN-1];
    mag_a    = sa_in ? -SrcAE : SrcAE;
    mag_b    = sb_in ? -SrcBE : SrcBE;
    div0     = MulDivOpE[2] && SrcBE == '0;
    ovf      = (MulDivOpE == 3'b100 || MulDivOpE == 3'b110) && SrcAE == {1'b1, {(XLEN-1){1'b0}}} && SrcBE == '1;
    special  = div0 || ovf;
    // div-by-zero: quotient all-ones, remainder = dividend; overflow: quotient = dividend, remainder 0
    spec_res = div0 ? (MulDivOpE[1] ? SrcAE : '1) : (MulDivOpE[1] ? '0 : SrcAE);
    accept   = state == IDLE && StartE && !FlushE;
    acc_add  = a[0] ? acc + b : acc;
    rem_sh   = {acc[XLEN-1:0], a[XLEN-1]};
    diff     = rem_sh - {1'b0, b[XLEN-1:0]};
    ge       = rem_sh >= {1'b0, b[XLEN-1:0]};
    rem_nx   = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx   = {a[XLEN-2:0], ge};
    acc_n    = op[2] ? {{XLEN{1'b0}}, rem_nx} : acc_add;
    b_n      = op[2] ? b : b << 1;
    a_n      = op[2] ? quo_nx : a >> 1;
    prod_s   = neg_q ? -acc_add : acc_add;
    mul_res  = op[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_res  = op[1] ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
    res_calc = op[2] ? div_res : mul_res;
  end
  always_comb begin
    state_n = FlushE ? IDLE :
              state == IDLE ? (StartE ? (special ? DONE : CALC) : IDLE) :
              state == CALC ? (count == LAST ? DONE : CALC) : IDLE;
    StallMD = !FlushE && ((state == IDLE && StartE) || state == CALC);
    BusyE = state == CALC;
    DoneE = state == DONE && !FlushE;
    MulDivResultE = DoneE ? res : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      op    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      acc   <= '0;
      b     <= '0;
      a     <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op    <= MulDivOpE;
        neg_q <= sa_in ^ sb_in;
        neg_r <= sa_in;
        count <= '0;
        acc   <= '0;
        a     <= mag_a;
        b     <= {{XLEN{1'b0}}, mag_b};
        res   <= spec_res;
      end else if (state == CALC) begin
        count <= count + 1'b1;
        acc   <= acc_n;
        a     <= a_n;
        b     <= b_n;
        if (count == LAST) res <= res_calc;
      end
    end
  end
endmodule
